// File: rtl/eq_bool_bool_bool.sv
// eq_bool_bool_bool: 1-bit equality (XNOR) primitive.
// The output can be combinational or registered on clock. The clock and reset
// ports exist in both modes so every primitive in the library has the same
// port list.
module eq_bool_bool_bool #(
  parameter int unsigned OUT_REG   = 0,    // 0: combinational, 1: registered
  parameter int unsigned RESET_VAL = 1'b0  // register value while reset is low
) (
  input  logic clock,
  input  logic reset,   // asynchronous, active low
  input  logic a,
  input  logic b,
  output logic y
);

  logic eq_c;

  // Compare the two operands
  assign eq_c = ~(a ^ b);

  // Only 0 and 1 are meaningful for either parameter
  generate
    if (OUT_REG > 1 || RESET_VAL > 1) begin : g_cfg_err
      $error("eq_bool_bool_bool: OUT_REG and RESET_VAL must each be 0 or 1");
    end
  endgenerate

  generate
    if (OUT_REG == 1) begin : g_reg
      localparam logic RST_BIT = (RESET_VAL != 0);
      logic y_q;

      // Output flop; reset forces RESET_VAL without waiting for a clock edge
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          y_q <= RST_BIT;
        end else begin
          y_q <= eq_c;
        end
      end

      assign y = y_q;
    end else begin : g_comb
      // Clock and reset are unused in this mode; fold them into a sink
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;

      // Output follows the operands directly, even while reset is low
      assign y = eq_c;
    end
  endgenerate

endmodule

// File: tb/tb_eq_bool_bool_bool.sv
// Scoreboard bench for eq_bool_bool_bool in combinational and registered modes
module tb_eq_bool_bool_bool;

  logic clock;
  logic reset;
  logic a;
  logic b;
  logic y_comb;
  logic y_reg0;
  logic y_reg1;

  int checks = 0;
  int errors = 0;

  logic q_comb [$];
  logic q_reg  [$];

  // {a, b, y}: 17 entries cover all 16 ordered transitions between input pairs
  logic [2:0] sweep [17] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100,
                             3'b111, 3'b111, 3'b001, 3'b100, 3'b001, 3'b111,
                             3'b010, 3'b111, 3'b100, 3'b010, 3'b001};

  eq_bool_bool_bool #(.OUT_REG(0), .RESET_VAL(0)) u_comb (
    .clock(clock), .reset(reset), .a(a), .b(b), .y(y_comb));

  eq_bool_bool_bool #(.OUT_REG(1), .RESET_VAL(0)) u_reg0 (
    .clock(clock), .reset(reset), .a(a), .b(b), .y(y_reg0));

  eq_bool_bool_bool #(.OUT_REG(1), .RESET_VAL(1)) u_reg1 (
    .clock(clock), .reset(reset), .a(a), .b(b), .y(y_reg1));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply a pair now and queue the expected result for both monitors
  task automatic drive_now(input logic av, input logic bv, input logic yv);
    a = av;
    b = bv;
    q_comb.push_back(yv);
    q_reg.push_back(yv);
  endtask

  task automatic drive(input logic av, input logic bv, input logic yv);
    @(posedge clock);
    #2;
    drive_now(av, bv, yv);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (q_comb.size() == 0 && q_reg.size() == 0) break;
      @(posedge clock);
      #3;
    end
    checks++;
    if (q_comb.size() != 0 || q_reg.size() != 0) begin
      errors++;
      $display("FAIL drain: pending comb=%0d reg=%0d required=0", q_comb.size(), q_reg.size());
    end
  endtask

  // Combinational monitor: same-cycle result, sampled on the falling edge
  initial begin
    logic e;
    forever begin
      @(negedge clock);
      if (q_comb.size() > 0) begin
        e = q_comb.pop_front();
        check("comb_y", y_comb, e);
      end
    end
  end

  // Registered monitor: result of the pair captured at this rising edge
  initial begin
    logic e;
    forever begin
      @(posedge clock);
      #1;
      if (q_reg.size() > 0) begin
        e = q_reg.pop_front();
        check("reg0_y", y_reg0, e);
        check("reg1_y", y_reg1, e);
      end
    end
  end

  initial begin
    reset = 1'b0;
    a = 1'b0;
    b = 1'b0;
    repeat (2) @(posedge clock);
    #3;
    check("rst_comb_00", y_comb, 1'b1);
    check("rst_reg0_val", y_reg0, 1'b0);
    check("rst_reg1_val", y_reg1, 1'b1);
    a = 1'b1;
    #1;
    check("rst_comb_10", y_comb, 1'b0);
    a = 1'b0;

    // Release between edges; first capture is on the next rising edge
    @(posedge clock);
    #2;
    reset = 1'b1;
    drive_now(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 17; i++) begin
      drive(sweep[i][2], sweep[i][1], sweep[i][0]);
    end

    // Mid-cycle reset pulse with a=b=1
    drive(1'b1, 1'b1, 1'b1);
    drain();
    @(posedge clock);
    #3;
    check("pulse_comb_pre", y_comb, 1'b1);
    check("pulse_reg0_pre", y_reg0, 1'b1);
    reset = 1'b0;
    #1;
    check("pulse_comb_low", y_comb, 1'b1);
    check("pulse_reg0_async", y_reg0, 1'b0);
    check("pulse_reg1_async", y_reg1, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check("pulse_comb_post", y_comb, 1'b1);
    check("pulse_reg0_hold", y_reg0, 1'b0);

    // Assert reset between edges with a=b=0, hold across an edge, then latency
    @(posedge clock);
    #2;
    a = 1'b0;
    b = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check("rst2_reg0_async", y_reg0, 1'b0);
    check("rst2_reg1_async", y_reg1, 1'b1);
    check("rst2_comb", y_comb, 1'b1);
    @(posedge clock);
    #1;
    check("rst2_reg0_hold", y_reg0, 1'b0);
    check("rst2_reg1_hold", y_reg1, 1'b1);
    #1;
    reset = 1'b1;
    drive_now(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
